// File: rtl/button_step_generator_pkg.sv
// Shared types and default timing for the button step generator.
// Default timing assumes a 50 MHz system clock.
package button_step_generator_pkg;

    // Per-channel sequencing state
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } chan_state_e;

    localparam int unsigned CLK_HZ_DEFAULT = 50_000_000;

    // Cycle count for a duration in milliseconds at the given clock frequency.
    function automatic int unsigned ms_to_cycles(input int unsigned ms,
                                                 input int unsigned clk_hz);
        return (clk_hz / 1000) * ms;
    endfunction

    localparam int unsigned DEBOUNCE_CYC_DEFAULT  = ms_to_cycles(10,  CLK_HZ_DEFAULT);
    localparam int unsigned REPEAT_DELAY_DEFAULT  = ms_to_cycles(500, CLK_HZ_DEFAULT);
    localparam int unsigned REPEAT_PERIOD_DEFAULT = ms_to_cycles(100, CLK_HZ_DEFAULT);
    localparam int unsigned CNT_W_DEFAULT         = 25;

endpackage

// File: rtl/button_step_generator_if.sv
// Button-side bundle: raw active-low buttons in, conditioned level and pulses out.
interface button_step_generator_if #(
    parameter int unsigned NUM_BTN = 3
);
    logic [NUM_BTN-1:0] i_btn_n;
    logic [NUM_BTN-1:0] o_pressed;
    logic [NUM_BTN-1:0] o_step;
    logic [NUM_BTN-1:0] o_release;

    // Stimulus/consumer side: drives the buttons, observes the conditioned outputs
    modport master (
        output i_btn_n,
        input  o_pressed,
        input  o_step,
        input  o_release
    );

    // Generator side
    modport slave (
        input  i_btn_n,
        output o_pressed,
        output o_step,
        output o_release
    );
endinterface

// File: rtl/button_step_generator_btn_channel.sv
// One button channel: 2-flop synchroniser, debounce counter, step/repeat FSM.
// Hold-to-repeat is built only when BTN_AUTOREPEAT_EN is defined; otherwise
// each accepted press yields exactly one step and the repeat counter is absent.
//
//   state  | meaning
//   IDLE   | button released (debounced)
//   HELD   | pressed, waiting out the initial repeat delay
//   REPEAT | pressed, stepping every repeat period
module btn_channel
    import button_step_generator_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC  = DEBOUNCE_CYC_DEFAULT,
    parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEFAULT,
    parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEFAULT,
    parameter int unsigned CNT_W         = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_n,
    output logic o_pressed,
    output logic o_step,
    output logic o_release
);

    if (DEBOUNCE_CYC < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_timing
        $error("btn_channel: DEBOUNCE_CYC, REPEAT_DELAY and REPEAT_PERIOD must each be >= 2");
    end
    if (CNT_W > 32 || CNT_W == 0) begin : g_bad_width
        $error("btn_channel: CNT_W must be 1..32");
    end else if (64'(DEBOUNCE_CYC) > (64'd1 << CNT_W) ||
                 64'(REPEAT_DELAY) > (64'd1 << CNT_W) ||
                 64'(REPEAT_PERIOD) > (64'd1 << CNT_W)) begin : g_narrow_cnt
        $error("btn_channel: CNT_W too narrow for the timing parameters");
    end

    localparam logic [CNT_W-1:0] DCNT_TC = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic             pressed_q, pressed_d;
    logic             step_q, step_d;
    logic             release_q, release_d;
    chan_state_e      state_q, state_d;
    logic             sample;
    logic             differ;
    logic             accept;

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_TC  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_TC = CNT_W'(REPEAT_PERIOD - 1);
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
`endif

    // Synchroniser shift and debounce: count consecutive differing samples, toggle at terminal count
    always_comb begin
        sync_d    = {sync_q[0], i_btn_n};
        sample    = ~sync_q[1];
        differ    = sample ^ pressed_q;
        accept    = differ && (dcnt_q == DCNT_TC);
        dcnt_d    = '0;
        pressed_d = pressed_q;
        if (differ && !accept) begin
            dcnt_d = dcnt_q + CNT_W'(1);
        end
        if (accept) begin
            pressed_d = ~pressed_q;
        end
    end

    // Step/release sequencing; a release always wins over a coincident repeat step
    always_comb begin
        state_d   = state_q;
        step_d    = 1'b0;
        release_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        rcnt_d    = rcnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept && sample) begin
                    step_d  = 1'b1;
                    state_d = HELD;
`ifdef BTN_AUTOREPEAT_EN
                    rcnt_d  = '0;
`endif
                end
            end
            HELD: begin
                if (accept && !sample) begin
                    release_d = 1'b1;
                    state_d   = IDLE;
`ifdef BTN_AUTOREPEAT_EN
                    rcnt_d    = '0;
                end else if (rcnt_q == DELAY_TC) begin
                    step_d  = 1'b1;
                    rcnt_d  = '0;
                    state_d = REPEAT;
                end else begin
                    rcnt_d = rcnt_q + CNT_W'(1);
`endif
                end
            end
`ifdef BTN_AUTOREPEAT_EN
            REPEAT: begin
                if (accept && !sample) begin
                    release_d = 1'b1;
                    state_d   = IDLE;
                    rcnt_d    = '0;
                end else if (rcnt_q == PERIOD_TC) begin
                    step_d = 1'b1;
                    rcnt_d = '0;
                end else begin
                    rcnt_d = rcnt_q + CNT_W'(1);
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Channel registers; reset leaves the synchroniser reading "released"
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= 2'b11;
            dcnt_q    <= '0;
            pressed_q <= 1'b0;
            step_q    <= 1'b0;
            release_q <= 1'b0;
            state_q   <= IDLE;
        end else begin
            sync_q    <= sync_d;
            dcnt_q    <= dcnt_d;
            pressed_q <= pressed_d;
            step_q    <= step_d;
            release_q <= release_d;
            state_q   <= state_d;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    // Repeat timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt_q <= '0;
        end else begin
            rcnt_q <= rcnt_d;
        end
    end
`endif

    assign o_pressed = pressed_q;
    assign o_step    = step_q;
    assign o_release = release_q;

endmodule

// File: rtl/button_step_generator.sv
// Button step generator top: NUM_BTN independent conditioned button channels.
// Optional hold-to-repeat selected by the BTN_AUTOREPEAT_EN macro.
module button_step_generator
    import button_step_generator_pkg::*;
#(
    parameter int unsigned NUM_BTN       = 3,
    parameter int unsigned DEBOUNCE_CYC  = DEBOUNCE_CYC_DEFAULT,
    parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEFAULT,
    parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEFAULT,
    parameter int unsigned CNT_W         = CNT_W_DEFAULT
) (
    input  logic                     CLK,
    input  logic                     RST,
    button_step_generator_if.slave   bus
);

    logic [NUM_BTN-1:0] pressed_w;
    logic [NUM_BTN-1:0] step_w;
    logic [NUM_BTN-1:0] release_w;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYC  (DEBOUNCE_CYC),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .CNT_W         (CNT_W)
        ) u_ch (
            .clk       (CLK),
            .rst       (RST),
            .i_btn_n   (bus.i_btn_n[g]),
            .o_pressed (pressed_w[g]),
            .o_step    (step_w[g]),
            .o_release (release_w[g])
        );
    end

    assign bus.o_pressed = pressed_w;
    assign bus.o_step    = step_w;
    assign bus.o_release = release_w;

endmodule

// File: tb/tb_button_step_generator.sv
// Scoreboard bench for button_step_generator (DEBOUNCE_CYC=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=5). Expected pulses are queued with their cycle number when the
// stimulus is applied; a monitor compares every output pulse against the queue.
module tb_button_step_generator;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 5;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;

    button_step_generator_if #(.NUM_BTN(3)) bif ();

    button_step_generator #(
        .NUM_BTN       (3),
        .DEBOUNCE_CYC  (DEB),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP),
        .CNT_W         (25)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bif.slave)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [2:0] step;
        logic [2:0] rel;
        logic [2:0] pressed;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic push(input int c, input logic [2:0] st, input logic [2:0] rl,
                        input logic [2:0] pr);
        exp_t e;
        e.cyc = c; e.step = st; e.rel = rl; e.pressed = pr;
        exp_q.push_back(e);
    endtask

    task automatic check3(input string name, input logic [2:0] act, input logic [2:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Monitor: flag overdue expectations, then match any presented pulse
    always @(negedge CLK) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_pulse: expected step=%b rel=%b at cyc %0d, still pending at cyc %0d",
                     e.step, e.rel, e.cyc, cyc);
        end
        if ((bif.o_step | bif.o_release) != 3'b000) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: cyc %0d step=%b rel=%b pressed=%b",
                         cyc, bif.o_step, bif.o_release, bif.o_pressed);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.step !== bif.o_step || e.rel !== bif.o_release ||
                    e.pressed !== bif.o_pressed) begin
                    miscompares++;
                    $display("FAIL pulse: got cyc %0d step=%b rel=%b pressed=%b, expected cyc %0d step=%b rel=%b pressed=%b",
                             cyc, bif.o_step, bif.o_release, bif.o_pressed,
                             e.cyc, e.step, e.rel, e.pressed);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int r;
        bif.i_btn_n = 3'b111;

        // Reset state
        wait_cyc(3);
        check3("reset_pressed", bif.o_pressed, 3'b000);
        check3("reset_step",    bif.o_step,    3'b000);
        check3("reset_release", bif.o_release, 3'b000);
        RST = 1'b0;
        wait_cyc(3);

        // Clean press on btn0, held 10 cycles
        c = cyc;
        bif.i_btn_n = 3'b110;
        push(c + 6, 3'b001, 3'b000, 3'b001);
        wait_cyc(10);
        check3("clean_held_level", bif.o_pressed, 3'b001);
        c = cyc;
        bif.i_btn_n = 3'b111;
        push(c + 6, 3'b000, 3'b001, 3'b000);
        wait_cyc(12);

        // Bouncy press on btn0: 2-cycle toggles, then stable low
        for (int i = 0; i < 6; i++) begin
            bif.i_btn_n[0] = i[0];
            repeat (2) begin
                @(negedge CLK);
                check3("bounce_no_glitch", bif.o_pressed, 3'b000);
            end
        end
        c = cyc;
        bif.i_btn_n[0] = 1'b0;
        push(c + 6, 3'b001, 3'b000, 3'b001);
        wait_cyc(10);
        c = cyc;
        bif.i_btn_n[0] = 1'b1;
        push(c + 6, 3'b000, 3'b001, 3'b000);
        wait_cyc(12);

        // Hold btn1 for 60 cycles; final repeat slot coincides with accepted release
        c = cyc;
        bif.i_btn_n = 3'b101;
        push(c + 6, 3'b010, 3'b000, 3'b010);
`ifdef BTN_AUTOREPEAT_EN
        for (int k = 0; k < 8; k++) push(c + 6 + RD + RP * k, 3'b010, 3'b000, 3'b010);
`endif
        wait_cyc(60);
        check3("long_hold_level", bif.o_pressed, 3'b010);
        c = cyc;
        bif.i_btn_n = 3'b111;
        push(c + 6, 3'b000, 3'b010, 3'b000);
        wait_cyc(12);

        // Simultaneous press of btn0 and btn2
        c = cyc;
        bif.i_btn_n = 3'b010;
        push(c + 6, 3'b101, 3'b000, 3'b101);
`ifdef BTN_AUTOREPEAT_EN
        push(c + 26, 3'b101, 3'b000, 3'b101);
        push(c + 31, 3'b101, 3'b000, 3'b101);
        push(c + 36, 3'b101, 3'b000, 3'b101);
`endif
        wait_cyc(33);
        c = cyc;
        bif.i_btn_n = 3'b111;
        push(c + 6, 3'b000, 3'b101, 3'b000);
        wait_cyc(12);

        // Release on btn2 accepted exactly when the repeat timer would fire
        c = cyc;
        bif.i_btn_n = 3'b011;
        push(c + 6, 3'b100, 3'b000, 3'b100);
`ifdef BTN_AUTOREPEAT_EN
        push(c + 26, 3'b100, 3'b000, 3'b100);
        push(c + 31, 3'b100, 3'b000, 3'b100);
`endif
        wait_cyc(30);
        bif.i_btn_n = 3'b111;
        push(c + 36, 3'b000, 3'b100, 3'b000);
        wait_cyc(12);

        // Reset pulsed while btn1 is held (in REPEAT when auto-repeat is built)
        c = cyc;
        bif.i_btn_n = 3'b101;
        push(c + 6, 3'b010, 3'b000, 3'b010);
`ifdef BTN_AUTOREPEAT_EN
        push(c + 26, 3'b010, 3'b000, 3'b010);
`endif
        wait_cyc(28);
        check3("pre_reset_level", bif.o_pressed, 3'b010);
        RST = 1'b1;
        #1;
        check3("async_reset_pressed", bif.o_pressed, 3'b000);
        check3("async_reset_step",    bif.o_step,    3'b000);
        check3("async_reset_release", bif.o_release, 3'b000);
        wait_cyc(3);
        RST = 1'b0;
        r = cyc;
        push(r + 6, 3'b010, 3'b000, 3'b010);
        wait_cyc(10);
        c = cyc;
        bif.i_btn_n = 3'b111;
        push(c + 6, 3'b000, 3'b010, 3'b000);
        wait_cyc(15);

        check3("final_level", bif.o_pressed, 3'b000);
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL leftover: expected step=%b rel=%b at cyc %0d never seen",
                     e.step, e.rel, e.cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
